// File: rtl/key_delivery_unit.sv
// key_delivery_unit: loads a secret key serially from the key store and
// checks it with an even-parity bit. Only a verified key is applied to the
// key_* inputs of a logic-locked core. Until then the core sees the DECOY
// value. Repeated parity failures force a sticky LOCKOUT that only rst
// clears.
// Optional feature: define KDU_ZEROIZE_EN to add a zeroize input. Zeroize
// wipes the key and returns the unit to IDLE without touching the fail count.
module key_delivery_unit #(
    parameter int               KEY_W    = 2,
    parameter int               MAX_FAIL = 3,
    parameter logic [KEY_W-1:0] DECOY    = {KEY_W{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
`ifdef KDU_ZEROIZE_EN
    input  logic             zeroize,
`endif
    input  logic             start,
    input  logic             kin_valid,
    input  logic             kin_data,
    output logic             kin_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             busy,
    output logic             err,
    output logic             lockout
);

    localparam int               CNT_W      = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST_C = CNT_W'(KEY_W - 1);
    localparam logic [3:0]       MAX_FAIL_C = 4'(MAX_FAIL);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT   = 3'd1,
        S_PARITY  = 3'd2,
        S_ARMED   = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t           state_r;
    logic [KEY_W-1:0] shreg_r;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       fail_r;

    logic             xfer_s;
    logic [3:0]       fail_inc_s;
    logic             par_bad_s;

    // Reduction parity of the captured key bits.
    function automatic logic key_parity(input logic [KEY_W-1:0] v);
        return ^v;
    endfunction

    // Handshake decode and parity check of the bit on the input this cycle.
    always_comb begin
        xfer_s     = kin_valid & kin_ready;
        fail_inc_s = fail_r + 4'd1;
        par_bad_s  = key_parity(shreg_r) ^ kin_data;
    end

    // Load FSM. All outputs are registered and updated with each state move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            shreg_r   <= {KEY_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            fail_r    <= 4'd0;
            key_out   <= DECOY;
            key_valid <= 1'b0;
            kin_ready <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            lockout   <= 1'b0;
        end else begin
            err <= 1'b0;
`ifdef KDU_ZEROIZE_EN
            // Zeroize beats start and bit transfers, but cannot leave LOCKOUT.
            if (zeroize && (state_r != S_LOCKOUT)) begin
                state_r   <= S_IDLE;
                shreg_r   <= {KEY_W{1'b0}};
                cnt_r     <= {CNT_W{1'b0}};
                key_out   <= DECOY;
                key_valid <= 1'b0;
                kin_ready <= 1'b0;
                busy      <= 1'b0;
            end else
`endif
            begin
                case (state_r)
                    S_IDLE: begin
                        if (start) begin
                            state_r   <= S_SHIFT;
                            shreg_r   <= {KEY_W{1'b0}};
                            cnt_r     <= {CNT_W{1'b0}};
                            kin_ready <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            state_r   <= S_IDLE;
                        end
                    end
                    S_SHIFT: begin
                        if (xfer_s) begin
                            shreg_r[cnt_r] <= kin_data;
                            cnt_r          <= cnt_r + CNT_W'(1'b1);
                            if (cnt_r == CNT_LAST_C) begin
                                state_r <= S_PARITY;
                            end else begin
                                state_r <= S_SHIFT;
                            end
                        end else begin
                            state_r <= S_SHIFT;
                        end
                    end
                    S_PARITY: begin
                        if (xfer_s) begin
                            kin_ready <= 1'b0;
                            busy      <= 1'b0;
                            if (!par_bad_s) begin
                                // Key becomes visible on the parity-accept edge.
                                state_r   <= S_ARMED;
                                key_out   <= shreg_r;
                                key_valid <= 1'b1;
                                fail_r    <= 4'd0;
                            end else begin
                                fail_r <= fail_inc_s;
                                err    <= 1'b1;
                                if (fail_inc_s == MAX_FAIL_C) begin
                                    state_r <= S_LOCKOUT;
                                    lockout <= 1'b1;
                                end else begin
                                    state_r <= S_IDLE;
                                end
                            end
                        end else begin
                            state_r <= S_PARITY;
                        end
                    end
                    S_ARMED: begin
                        if (start) begin
                            // Withdraw the old key before any new bit arrives.
                            state_r   <= S_SHIFT;
                            key_out   <= DECOY;
                            key_valid <= 1'b0;
                            shreg_r   <= {KEY_W{1'b0}};
                            cnt_r     <= {CNT_W{1'b0}};
                            kin_ready <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            state_r <= S_ARMED;
                        end
                    end
                    S_LOCKOUT: begin
                        state_r   <= S_LOCKOUT;
                        key_out   <= DECOY;
                        key_valid <= 1'b0;
                        kin_ready <= 1'b0;
                        busy      <= 1'b0;
                        lockout   <= 1'b1;
                    end
                    default: begin
                        state_r   <= S_IDLE;
                        key_out   <= DECOY;
                        key_valid <= 1'b0;
                        kin_ready <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_delivery_unit.sv
// Scoreboard bench for key_delivery_unit (KEY_W=2, MAX_FAIL=3, DECOY=0).
// Stimulus pushes the expected arm/err event into a queue. A monitor pops
// and compares whenever the DUT raises key_valid or pulses err.
module tb_key_delivery_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       zeroize = 1'b0;
    logic       start = 1'b0;
    logic       kin_valid = 1'b0;
    logic       kin_data = 1'b0;
    logic       kin_ready;
    logic [1:0] key_out;
    logic       key_valid;
    logic       busy;
    logic       err;
    logic       lockout;

    typedef struct packed {
        logic       is_err;
        logic [1:0] key;
        logic       lock;
    } exp_t;

    exp_t exp_q[$];
    int   vec_cnt  = 0;
    int   fail_cnt = 0;
    logic prev_kv  = 1'b0;
    logic prev_err = 1'b0;

    key_delivery_unit #(.KEY_W(2), .MAX_FAIL(3), .DECOY(2'b00)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef KDU_ZEROIZE_EN
        .zeroize   (zeroize),
`endif
        .start     (start),
        .kin_valid (kin_valid),
        .kin_data  (kin_data),
        .kin_ready (kin_ready),
        .key_out   (key_out),
        .key_valid (key_valid),
        .busy      (busy),
        .err       (err),
        .lockout   (lockout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares each DUT event against the head of the queue.
    always @(negedge clk) begin
        if (prev_err) begin
            vec_cnt++;
            if (err) begin
                fail_cnt++;
                $display("FAIL err_width: err high two cycles, got 1 expected 0");
            end
        end
        if (err || (key_valid && !prev_kv)) begin
            vec_cnt++;
            if (exp_q.size() == 0) begin
                fail_cnt++;
                $display("FAIL event: unexpected event err=%0b key_out=%0h key_valid=%0b", err, key_out, key_valid);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_err) begin
                    if (!(err && key_out == 2'b00 && !key_valid && lockout == e.lock)) begin
                        fail_cnt++;
                        $display("FAIL err_event: got err=%0b key=%0h kv=%0b lock=%0b expected err=1 key=0 kv=0 lock=%0b",
                                 err, key_out, key_valid, lockout, e.lock);
                    end
                end else begin
                    if (!(!err && key_valid && key_out == e.key && !busy)) begin
                        fail_cnt++;
                        $display("FAIL arm_event: got err=%0b key=%0h kv=%0b busy=%0b expected err=0 key=%0h kv=1 busy=0",
                                 err, key_out, key_valid, busy, e.key);
                    end
                end
            end
        end
        prev_err = err;
        prev_kv  = key_valid;
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        int n;
        n = 0;
        repeat (gap) @(negedge clk);
        kin_valid = 1'b1;
        kin_data  = b;
        while (!kin_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!kin_ready) begin
            vec_cnt++;
            fail_cnt++;
            $display("FAIL handshake: kin_ready got 0 expected 1 within 20 cycles");
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        kin_valid = 1'b0;
    endtask

    task automatic load(input logic [1:0] key, input logic par, input int gap,
                        input logic is_err, input logic lock);
        exp_t e;
        e.is_err = is_err;
        e.key    = key;
        e.lock   = lock;
        exp_q.push_back(e);
        do_start();
        send_bit(key[0], gap);
        send_bit(key[1], gap);
        send_bit(par, gap);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // Reset state
        chk("rst_key_out",   {6'd0, key_out},   8'd0);
        chk("rst_key_valid", {7'd0, key_valid}, 8'd0);
        chk("rst_kin_ready", {7'd0, kin_ready}, 8'd0);
        chk("rst_busy",      {7'd0, busy},      8'd0);
        chk("rst_lockout",   {7'd0, lockout},   8'd0);

        // 1: good load 0,1 parity 1 -> 2'b10
        load(2'b10, 1'b1, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_busy_after", {7'd0, busy}, 8'd0);
        chk("t1_key_held",   {6'd0, key_out}, 8'h2);

        // 2: bad parity (fail count 1)
        load(2'b10, 1'b0, 0, 1'b1, 1'b0);
        @(negedge clk);
        chk("t2_key_out",   {6'd0, key_out},   8'd0);
        chk("t2_key_valid", {7'd0, key_valid}, 8'd0);
        chk("t2_idle_rdy",  {7'd0, kin_ready}, 8'd0);

        // 4: arm 2'b10 (clears fail count), reload from ARMED with gaps
        load(2'b10, 1'b1, 0, 1'b0, 1'b0);
        @(negedge clk);
        do_start();
        chk("t4_key_decoy", {6'd0, key_out},   8'd0);
        chk("t4_kv_low",    {7'd0, key_valid}, 8'd0);
        chk("t4_busy",      {7'd0, busy},      8'd1);
        begin
            exp_t e;
            e.is_err = 1'b0;
            e.key    = 2'b11;
            e.lock   = 1'b0;
            exp_q.push_back(e);
        end
        send_bit(1'b1, 2);
        chk("t4_partial_hidden", {6'd0, key_out}, 8'd0);
        send_bit(1'b1, 3);
        send_bit(1'b0, 2);
        @(negedge clk);
        chk("t4_key_held", {6'd0, key_out}, 8'h3);

        // 5: async reset mid-SHIFT between edges
        do_start();
        send_bit(1'b0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_key_out",   {6'd0, key_out},   8'd0);
        chk("t5_key_valid", {7'd0, key_valid}, 8'd0);
        chk("t5_kin_ready", {7'd0, kin_ready}, 8'd0);
        chk("t5_busy",      {7'd0, busy},      8'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load(2'b10, 1'b1, 0, 1'b0, 1'b0);
        @(negedge clk);

        // 3: three consecutive bad loads -> lockout
        load(2'b10, 1'b0, 0, 1'b1, 1'b0);
        load(2'b10, 1'b0, 1, 1'b1, 1'b0);
        load(2'b10, 1'b0, 0, 1'b1, 1'b1);
        @(negedge clk);
        chk("t3_lockout", {7'd0, lockout}, 8'd1);
        do_start();
        kin_valid = 1'b1;
        kin_data  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_lock_rdy", {7'd0, kin_ready}, 8'd0);
            chk("t3_lock_key", {6'd0, key_out},   8'd0);
            @(negedge clk);
        end
        kin_valid = 1'b0;
        chk("t3_lock_sticky", {7'd0, lockout}, 8'd1);
        do_reset();
        chk("t3_rst_exit", {7'd0, lockout}, 8'd0);

`ifdef KDU_ZEROIZE_EN
        // 6: zeroize with simultaneous start while armed
        load(2'b10, 1'b1, 0, 1'b0, 1'b0);
        @(negedge clk);
        zeroize = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        start   = 1'b0;
        chk("t6_key_out",   {6'd0, key_out},   8'd0);
        chk("t6_key_valid", {7'd0, key_valid}, 8'd0);
        chk("t6_idle_rdy",  {7'd0, kin_ready}, 8'd0);
        chk("t6_no_err",    {7'd0, err},       8'd0);
        // fail count survives zeroize
        load(2'b10, 1'b0, 0, 1'b1, 1'b0);
        load(2'b10, 1'b0, 0, 1'b1, 1'b0);
        do_start();
        send_bit(1'b0, 0);
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        chk("t6_zero_rdy",  {7'd0, kin_ready}, 8'd0);
        chk("t6_zero_lock", {7'd0, lockout},   8'd0);
        load(2'b10, 1'b0, 0, 1'b1, 1'b1);
        @(negedge clk);
        chk("t6_lockout", {7'd0, lockout}, 8'd1);
        do_reset();
`endif

        repeat (3) @(negedge clk);
        chk("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule
